// File: rtl/dmx_frame_ctrl.sv
// -----------------------------------------------------------------------------
// dmx_frame_ctrl
//
// Purpose
//   Collects decoded DMX slots into a double-buffered channel store of
//   CHANNEL_COUNT bytes starting at a configurable DMX start address. A frame
//   becomes visible to the read port only once every addressed slot has
//   arrived. The read side always sees a complete committed frame, and the
//   write side fills the other bank. Signal loss is declared when no frame has
//   been committed for TIMEOUT_COUNT clock cycles.
//
// Configuration macro
//   DMX_HOLD_LAST_EN : when defined, the read port keeps returning the last
//                      committed frame during signal loss. When undefined
//                      (default), the read port returns 8'h00 while
//                      signal_lost is high, which blacks out the fixture.
//
// Ports
//   clk            in   1                  system clock
//   rst_n          in   1                  asynchronous active-low reset
//   start_addr     in   MAX_CHANNEL_BITS+1 first DMX data slot owned here
//   frame_sync     in   1                  new-frame pulse (valid start code)
//   in_strobe      in   1                  slot-valid pulse
//   in_channel     in   MAX_CHANNEL_BITS+1 slot index with in_strobe
//   in_data        in   8                  slot value with in_strobe
//   rd_addr        in   IDX_W              read index into committed frame
//   rd_data        out  8                  committed value, 1-cycle latency
//   frame_valid    out  1                  a frame is committed, no signal loss
//   commit_strobe  out  1                  1-cycle pulse on frame commit
//   frame_count    out  8                  committed frames, wraps 255->0
//   signal_lost    out  1                  timeout expired since last commit
// -----------------------------------------------------------------------------
module dmx_frame_ctrl #(
  parameter int MAX_CHANNEL_BITS = 8,
  parameter int CHANNEL_COUNT    = 8,
  parameter int TIMEOUT_COUNT    = 48000000,
  parameter int TIMEOUT_BITS     = 26,
  localparam int IDX_W = (CHANNEL_COUNT > 1) ? $clog2(CHANNEL_COUNT) : 1,
  localparam int CW    = MAX_CHANNEL_BITS + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CW-1:0]    start_addr,
  input  logic             frame_sync,
  input  logic             in_strobe,
  input  logic [CW-1:0]    in_channel,
  input  logic [7:0]       in_data,
  input  logic [IDX_W-1:0] rd_addr,
  output logic [7:0]       rd_data,
  output logic             frame_valid,
  output logic             commit_strobe,
  output logic [7:0]       frame_count,
  output logic             signal_lost
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_COMMIT  = 2'd2
  } state_e;

  localparam logic [CW:0]             CC_EXT = (CW+1)'(CHANNEL_COUNT);
  localparam logic [TIMEOUT_BITS-1:0] TO_MAX = TIMEOUT_BITS'(TIMEOUT_COUNT);

  state_e                   state_q, state_d;
  logic [CHANNEL_COUNT-1:0] rx_mask_q, rx_mask_d;
  logic [CW-1:0]            start_addr_q, start_addr_d;
  logic                     bank_q, bank_d;
  logic [TIMEOUT_BITS-1:0]  tmo_cnt_q, tmo_cnt_d;
  logic                     signal_lost_q, signal_lost_d;
  logic                     frame_valid_q, frame_valid_d;
  logic [7:0]               frame_count_q, frame_count_d;
  logic [7:0]               rd_data_q, rd_data_d;

  // Two banks; bank_q selects the one visible to the read port.
  logic [7:0] bank0_q [CHANNEL_COUNT];
  logic [7:0] bank1_q [CHANNEL_COUNT];

  logic                     commit;
  logic                     wr_en;
  logic                     in_win;
  logic [CW:0]              win_hi;
  logic [CW-1:0]            offset;
  logic [CHANNEL_COUNT-1:0] wr_hit;
  logic [7:0]               rd_val;
  logic                     blank;

  assign commit = (state_q == ST_COMMIT);

  // Window test is done on a one-bit-wider sum so a window running past the
  // top of the slot range does not wrap back to low slot numbers.
  always_comb begin
    win_hi = {1'b0, start_addr_q} + CC_EXT;
    in_win = (in_channel >= start_addr_q) && ({1'b0, in_channel} < win_hi);
    offset = in_channel - start_addr_q;
    wr_hit = '0;
    for (int i = 0; i < CHANNEL_COUNT; i++) begin
      wr_hit[i] = in_win && (offset == CW'(i));
    end
  end

  // Frame sequencing
  always_comb begin
    state_d      = state_q;
    rx_mask_d    = rx_mask_q;
    start_addr_d = start_addr_q;
    wr_en        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (frame_sync) begin
          state_d      = ST_COLLECT;
          rx_mask_d    = '0;
          start_addr_d = start_addr;
        end
      end
      ST_COLLECT: begin
        if (frame_sync) begin
          // A new start code abandons the partial frame.
          rx_mask_d    = '0;
          start_addr_d = start_addr;
        end else if (in_strobe && in_win) begin
          wr_en     = 1'b1;
          rx_mask_d = rx_mask_q | wr_hit;
          if (&rx_mask_d) begin
            state_d = ST_COMMIT;
          end
        end
      end
      ST_COMMIT: begin
        // Strobes arriving during the commit cycle are dropped.
        if (frame_sync) begin
          state_d      = ST_COLLECT;
          rx_mask_d    = '0;
          start_addr_d = start_addr;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Commit bookkeeping and timeout
  always_comb begin
    bank_d        = commit ? ~bank_q : bank_q;
    frame_count_d = commit ? (frame_count_q + 8'd1) : frame_count_q;
    if (commit) begin
      tmo_cnt_d = '0;
    end else if (tmo_cnt_q == TO_MAX) begin
      tmo_cnt_d = tmo_cnt_q;
    end else begin
      tmo_cnt_d = tmo_cnt_q + TIMEOUT_BITS'(1);
    end
    if (commit) begin
      signal_lost_d = 1'b0;
      frame_valid_d = 1'b1;
    end else if (tmo_cnt_d == TO_MAX) begin
      signal_lost_d = 1'b1;
      frame_valid_d = 1'b0;
    end else begin
      signal_lost_d = signal_lost_q;
      frame_valid_d = frame_valid_q;
    end
  end

  // Read port: out-of-range indices never match the decode and read as zero.
  always_comb begin
    rd_val = 8'h00;
    for (int i = 0; i < CHANNEL_COUNT; i++) begin
      if ({1'b0, rd_addr} == (IDX_W+1)'(i)) begin
        rd_val = bank_q ? bank1_q[i] : bank0_q[i];
      end
    end
`ifdef DMX_HOLD_LAST_EN
    blank = 1'b0;
`else
    blank = signal_lost_q;
`endif
    rd_data_d = blank ? 8'h00 : rd_val;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      rx_mask_q     <= '0;
      start_addr_q  <= '0;
      bank_q        <= 1'b0;
      tmo_cnt_q     <= '0;
      signal_lost_q <= 1'b1;
      frame_valid_q <= 1'b0;
      frame_count_q <= 8'h00;
      rd_data_q     <= 8'h00;
    end else begin
      state_q       <= state_d;
      rx_mask_q     <= rx_mask_d;
      start_addr_q  <= start_addr_d;
      bank_q        <= bank_d;
      tmo_cnt_q     <= tmo_cnt_d;
      signal_lost_q <= signal_lost_d;
      frame_valid_q <= frame_valid_d;
      frame_count_q <= frame_count_d;
      rd_data_q     <= rd_data_d;
    end
  end

  // Writes always land in the shadow bank (the one not selected by bank_q).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNEL_COUNT; i++) begin
        bank0_q[i] <= 8'h00;
        bank1_q[i] <= 8'h00;
      end
    end else begin
      for (int i = 0; i < CHANNEL_COUNT; i++) begin
        if (wr_en && wr_hit[i]) begin
          if (bank_q) begin
            bank0_q[i] <= in_data;
          end else begin
            bank1_q[i] <= in_data;
          end
        end
      end
    end
  end

  assign rd_data       = rd_data_q;
  assign frame_valid   = frame_valid_q;
  assign commit_strobe = commit;
  assign frame_count   = frame_count_q;
  assign signal_lost   = signal_lost_q;

endmodule

// File: tb/tb_dmx_frame_ctrl.sv
module tb_dmx_frame_ctrl;

  localparam int CC = 8;
  localparam int TC = 1000;
`ifdef DMX_HOLD_LAST_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [8:0] start_addr = '0;
  logic       frame_sync = 1'b0;
  logic       in_strobe = 1'b0;
  logic [8:0] in_channel = '0;
  logic [7:0] in_data = '0;
  logic [2:0] rd_addr = '0;
  logic [7:0] rd_data;
  logic       frame_valid, commit_strobe, signal_lost;
  logic [7:0] frame_count;

  // Second instance with a non-power-of-two depth so an index equal to
  // CHANNEL_COUNT is expressible on rd_addr.
  logic [2:0] rd_addr2 = '0;
  logic [7:0] rd_data2;
  logic       fv2, cs2, sl2;
  logic [7:0] fc2;

  dmx_frame_ctrl #(.MAX_CHANNEL_BITS(8), .CHANNEL_COUNT(CC),
                   .TIMEOUT_COUNT(TC), .TIMEOUT_BITS(10)) dut (
    .clk(clk), .rst_n(rst_n), .start_addr(start_addr), .frame_sync(frame_sync),
    .in_strobe(in_strobe), .in_channel(in_channel), .in_data(in_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .frame_valid(frame_valid),
    .commit_strobe(commit_strobe), .frame_count(frame_count), .signal_lost(signal_lost));

  dmx_frame_ctrl #(.MAX_CHANNEL_BITS(8), .CHANNEL_COUNT(5),
                   .TIMEOUT_COUNT(TC), .TIMEOUT_BITS(10)) dut2 (
    .clk(clk), .rst_n(rst_n), .start_addr(start_addr), .frame_sync(frame_sync),
    .in_strobe(in_strobe), .in_channel(in_channel), .in_data(in_data),
    .rd_addr(rd_addr2), .rd_data(rd_data2), .frame_valid(fv2),
    .commit_strobe(cs2), .frame_count(fc2), .signal_lost(sl2));

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int cs_seen = 0;
  int cs2_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // Committed frame, frame under construction, and the slot set received.
  logic [7:0] m_comm  [CC];
  logic [7:0] m_frame [CC];
  bit   [CC-1:0] m_mask;
  bit         m_collect, m_pend, m_lost, m_valid;
  logic [8:0] m_start;
  logic [7:0] m_count, m_rd;
  int         m_since;

  task automatic model_reset();
    for (int i = 0; i < CC; i++) begin m_comm[i] = 8'h00; m_frame[i] = 8'h00; end
    m_mask = '0; m_collect = 0; m_pend = 0; m_lost = 1; m_valid = 0;
    m_start = '0; m_count = 8'h00; m_rd = 8'h00; m_since = 0;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        model_reset();
      end else begin
        m_rd = (int'(rd_addr) < CC && !(m_lost && !HOLD)) ? m_comm[rd_addr] : 8'h00;
        if (m_pend) begin
          for (int i = 0; i < CC; i++) m_comm[i] = m_frame[i];
          m_count = m_count + 8'd1;
          m_since = 0; m_lost = 0; m_valid = 1; m_pend = 0;
          m_collect = frame_sync;
          if (frame_sync) begin m_mask = '0; m_start = start_addr; end
        end else begin
          if (m_since < TC) m_since++;
          if (m_since >= TC) begin m_lost = 1; m_valid = 0; end
          if (frame_sync) begin
            m_collect = 1; m_mask = '0; m_start = start_addr;
          end else if (m_collect && in_strobe && int'(in_channel) >= int'(m_start)
                       && int'(in_channel) < int'(m_start) + CC) begin
            m_frame[int'(in_channel) - int'(m_start)] = in_data;
            m_mask[int'(in_channel) - int'(m_start)] = 1'b1;
            if (&m_mask) begin m_pend = 1; m_collect = 0; end
          end
        end
      end
    end
  end

  // Per-cycle comparison against the model, sampled on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("commit_strobe", commit_strobe, m_pend);
        chk("frame_count",   frame_count,   m_count);
        chk("frame_valid",   frame_valid,   m_valid);
        chk("signal_lost",   signal_lost,   m_lost);
        chk("rd_data",       rd_data,       m_rd);
        if (commit_strobe) cs_seen++;
        if (cs2) cs2_seen++;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic sync_pulse();
    frame_sync = 1'b1; tick(); frame_sync = 1'b0;
  endtask

  task automatic send(input int ch, input int d);
    in_strobe = 1'b1; in_channel = 9'(ch); in_data = 8'(d);
    tick();
    in_strobe = 1'b0;
  endtask

  task automatic rd_chk(input string name, input int a, input int exp);
    rd_addr = 3'(a); tick(); chk(name, rd_data, exp);
  endtask

  task automatic rd2_chk(input string name, input int a, input int exp);
    rd_addr2 = 3'(a); tick(); chk(name, rd_data2, exp);
  endtask

  int cs0;
  int fc0;

  initial begin
    // 1: reset values for several read addresses
    for (int a = 0; a < 4; a++) begin
      rd_addr = 3'(a * 2 + 1);
      tick();
      chk("rst_rd_data", rd_data, 0);
      chk("rst_signal_lost", signal_lost, 1);
      chk("rst_frame_valid", frame_valid, 0);
      chk("rst_frame_count", frame_count, 0);
    end
    rst_n = 1'b1;
    tick();

    // 2: window at slot 10, strobes 0..20 with data = ch*3
    start_addr = 9'd10;
    sync_pulse();
    for (int ch = 0; ch <= 20; ch++) send(ch, ch * 3);
    tick();
    chk("t2_commits", cs_seen, 1);
    chk("t2_frame_count", frame_count, 1);
    chk("t2_frame_valid", frame_valid, 1);
    chk("t2_signal_lost", signal_lost, 0);
    rd_chk("t2_rd0", 0, 30);
    rd_chk("t2_rd7", 7, 51);
    chk("t2b_commits", cs2_seen, 1);
    chk("t2b_frame_count", fc2, 1);
    chk("t2b_frame_valid", fv2, 1);
    chk("t2b_signal_lost", sl2, 0);
    rd2_chk("t2b_rd4", 4, 42);
    rd2_chk("t2b_rd5_oob", 5, 0);
    rd2_chk("t2b_rd7_oob", 7, 0);

    // 3: partial frame abandoned by a new start code
    cs0 = cs_seen;
    sync_pulse();
    for (int ch = 10; ch <= 14; ch++) send(ch, 8'h11);
    tick();
    sync_pulse();
    for (int ch = 10; ch <= 17; ch++) send(ch, 8'hA5);
    tick(); tick();
    chk("t3_commits", cs_seen - cs0, 1);
    for (int a = 0; a < CC; a++) rd_chk("t3_rd", a, 8'hA5);

    // 4: start address change mid-frame takes effect on the next frame
    cs0 = cs_seen;
    sync_pulse();
    for (int ch = 10; ch <= 12; ch++) send(ch, ch + 100);
    start_addr = 9'd20;
    for (int ch = 13; ch <= 17; ch++) send(ch, ch + 100);
    tick();
    chk("t4_commits_old", cs_seen - cs0, 1);
    rd_chk("t4_rd3_old", 3, 113);
    sync_pulse();
    for (int ch = 20; ch <= 27; ch++) send(ch, ch);
    tick();
    chk("t4_commits_new", cs_seen - cs0, 2);
    rd_chk("t4_rd0_new", 0, 20);
    rd_chk("t4_rd7_new", 7, 27);

    // 5: timeout after a long idle period, cleared by the next frame
    repeat (TC + 5) tick();
    chk("t5_signal_lost", signal_lost, 1);
    chk("t5_frame_valid", frame_valid, 0);
    rd_chk("t5_rd0", 0, HOLD ? 20 : 0);
    rd_chk("t5_rd5", 5, HOLD ? 25 : 0);
    sync_pulse();
    for (int ch = 20; ch <= 27; ch++) send(ch, ch + 1);
    tick();
    chk("t5_signal_cleared", signal_lost, 0);
    chk("t5_valid_again", frame_valid, 1);
    rd_chk("t5_rd0_new", 0, 21);
    chk("t5_frame_count", frame_count, 5);

    // 6: 256 back-to-back frames, each next start code coinciding with a commit
    cs0 = cs_seen;
    fc0 = int'(frame_count);
    sync_pulse();
    for (int f = 0; f < 256; f++) begin
      for (int i = 0; i < CC; i++) send(20 + i, f + i);
      frame_sync = 1'b1; tick(); frame_sync = 1'b0;
    end
    tick();
    chk("t6_commits", cs_seen - cs0, 256);
    chk("t6_frame_count_wrap", frame_count, fc0);
    rd_chk("t6_rd3", 3, 2);
    rd_chk("t6_rd0", 0, 255);

    repeat (3) tick();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
